// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO family.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 128;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer indexing 0..depth-1 (at least one bit).
  function automatic int fifo_aw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clk edge; read is combinational from raddr.
// Backpressure: none; the caller guarantees writes only go to free slots.
//   ports: clk, we, waddr, wdata (write side); raddr, rdata (read side). No reset.
module fifo_mem_dp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO, DEPTH words (any size >= 2), full slot usage.
// Latency: FWFT=0 -> data_o one edge after an accepted read; FWFT=1 -> head word shown immediately.
// Backpressure: writes refused when full unless a read is accepted on the same edge (overflow_o sticks);
//   reads refused when empty (underflow_o sticks). Ports: clk, rst (async, low), clr_i (sync flush),
//   data_i/n_we_i write side, data_o/n_re_i read side, status flags, count_o, sticky error flags.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0,
  localparam int CW       = fifo_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             n_we_i,
  input  logic             n_re_i,
  output logic [WIDTH-1:0] data_o,
  output logic             p_empty_o,
  output logic             p_full_o,
  output logic             p_aempty_o,
  output logic             p_afull_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int            AW       = fifo_aw(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf, unf;
  logic             empty, full, rd_acc, wr_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A read frees the slot the same edge, so a full FIFO still takes a write alongside it.
  // An empty FIFO never takes a read, even with a concurrent write.
  assign rd_acc = !n_re_i && !empty;
  assign wr_acc = !n_we_i && (!full || rd_acc);

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !clr_i),
    .waddr (wr_ptr),
    .wdata (data_i),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (!n_we_i && full && !rd_acc) ovf <= 1'b1;
      if (!n_re_i && empty)           unf <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_o = empty ? '0 : mem_rdata;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        dout_q <= '0;
        else if (clr_i)  dout_q <= '0;
        else if (rd_acc) dout_q <= mem_rdata;
      end
      assign data_o = dout_q;
    end
  endgenerate

  // Thresholds compared as signed ints so out-of-range settings behave sensibly.
  assign p_empty_o   = empty;
  assign p_full_o    = full;
  assign p_aempty_o  = (int'(count) <= AEMPTY_TH);
  assign p_afull_o   = (int'(count) >= AFULL_TH);
  assign count_o     = count;
  assign overflow_o  = ovf;
  assign underflow_o = unf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: two DEPTH=5 instances (registered read and FWFT) on shared inputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_param_sync_fifo;

  localparam int D = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       n_we = 1'b1;
  logic       n_re = 1'b1;
  logic [7:0] din = '0;

  logic [7:0] a_data, b_data;
  logic [2:0] a_cnt, b_cnt;
  logic       a_empty, a_full, a_aempty, a_afull, a_ovf, a_unf;
  logic       b_empty, b_full, b_aempty, b_afull, b_ovf, b_unf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.WIDTH(8), .DEPTH(D), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .clr_i(clr), .data_i(din), .n_we_i(n_we), .n_re_i(n_re),
    .data_o(a_data), .p_empty_o(a_empty), .p_full_o(a_full), .p_aempty_o(a_aempty),
    .p_afull_o(a_afull), .count_o(a_cnt), .overflow_o(a_ovf), .underflow_o(a_unf));

  param_sync_fifo #(.WIDTH(8), .DEPTH(D), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst), .clr_i(clr), .data_i(din), .n_we_i(n_we), .n_re_i(n_re),
    .data_o(b_data), .p_empty_o(b_empty), .p_full_o(b_full), .p_aempty_o(b_aempty),
    .p_afull_o(b_afull), .count_o(b_cnt), .overflow_o(b_ovf), .underflow_o(b_unf));

  // Reference model: a queue of stored words plus the registered output and sticky flags.
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_update(input logic c, input logic we_n, input logic re_n, input logic [7:0] d);
    bit rd, wr;
    if (c) begin
      model_reset();
    end else begin
      rd = !re_n && (q.size() > 0);
      wr = !we_n && ((q.size() < D) || rd);
      if (!re_n && q.size() == 0) m_unf = 1'b1;
      if (!we_n && q.size() == D && !rd) m_ovf = 1'b1;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(d);
    end
  endtask

  task automatic model_check(input string tag);
    int n;
    logic [7:0] head;
    n    = q.size();
    head = (n > 0) ? q[0] : 8'h00;
    chk({tag, ":a_cnt"},    64'(a_cnt),    64'(n));
    chk({tag, ":a_data"},   64'(a_data),   64'(m_dout));
    chk({tag, ":a_empty"},  64'(a_empty),  64'(n == 0));
    chk({tag, ":a_full"},   64'(a_full),   64'(n == D));
    chk({tag, ":a_aempty"}, 64'(a_aempty), 64'(n <= 1));
    chk({tag, ":a_afull"},  64'(a_afull),  64'(n >= 3));
    chk({tag, ":a_ovf"},    64'(a_ovf),    64'(m_ovf));
    chk({tag, ":a_unf"},    64'(a_unf),    64'(m_unf));
    chk({tag, ":b_cnt"},    64'(b_cnt),    64'(n));
    chk({tag, ":b_data"},   64'(b_data),   64'(head));
    chk({tag, ":b_ovf"},    64'(b_ovf),    64'(m_ovf));
    chk({tag, ":b_unf"},    64'(b_unf),    64'(m_unf));
  endtask

  task automatic step(input logic c, input logic we_n, input logic re_n, input logic [7:0] d,
                      input string tag);
    @(negedge clk);
    clr  = c;
    n_we = we_n;
    n_re = re_n;
    din  = d;
    @(posedge clk);
    model_update(c, we_n, re_n, d);
    #1;
    model_check(tag);
  endtask

  typedef struct {
    logic       we_n;
    logic       re_n;
    logic [7:0] d;
    int         cnt;
    logic [7:0] dout;
    logic       afull;
    logic       full;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vec[13];

  initial begin
    // Fill past full, drain, one write+read while not full, then read on empty.
    vec[0]  = '{1'b0, 1'b1, 8'h01, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 8'h02, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 8'h03, 3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 8'h04, 4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 8'h05, 5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b1, 8'h06, 5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 8'h00, 4, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 8'h07, 4, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 8'h00, 3, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 8'h00, 2, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[10] = '{1'b1, 1'b0, 8'h00, 1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[11] = '{1'b1, 1'b0, 8'h00, 0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[12] = '{1'b1, 1'b0, 8'h00, 0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state while rst is held low.
    #12;
    chk("rst:cnt",    64'(a_cnt),    64'(0));
    chk("rst:empty",  64'(a_empty),  64'(1));
    chk("rst:aempty", 64'(a_aempty), 64'(1));
    chk("rst:full",   64'(a_full),   64'(0));
    chk("rst:afull",  64'(a_afull),  64'(0));
    chk("rst:data",   64'(a_data),   64'(0));
    chk("rst:ovf",    64'(a_ovf),    64'(0));
    chk("rst:unf",    64'(a_unf),    64'(0));
    chk("rst:b_data", 64'(b_data),   64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Table-driven fill/overflow/drain/underflow on the registered-read instance.
    step(1'b1, 1'b1, 1'b1, 8'h00, "tbl_clr");
    for (int i = 0; i < 13; i++) begin
      step(1'b0, vec[i].we_n, vec[i].re_n, vec[i].d, $sformatf("tbl%0d", i));
      chk($sformatf("vec%0d:cnt", i),   64'(a_cnt),   64'(vec[i].cnt));
      chk($sformatf("vec%0d:dout", i),  64'(a_data),  64'(vec[i].dout));
      chk($sformatf("vec%0d:afull", i), 64'(a_afull), 64'(vec[i].afull));
      chk($sformatf("vec%0d:full", i),  64'(a_full),  64'(vec[i].full));
      chk($sformatf("vec%0d:ovf", i),   64'(a_ovf),   64'(vec[i].ovf));
      chk($sformatf("vec%0d:unf", i),   64'(a_unf),   64'(vec[i].unf));
    end

    // Simultaneous write+read while full: both accepted, no overflow.
    step(1'b1, 1'b1, 1'b1, 8'h00, "full_clr");
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b1, 8'h20 + 8'(i), "full_fill");
    step(1'b0, 1'b0, 1'b0, 8'h77, "full_wr_rd");
    chk("full_wr_rd:cnt",  64'(a_cnt),  64'(D));
    chk("full_wr_rd:ovf",  64'(a_ovf),  64'(0));
    chk("full_wr_rd:dout", 64'(a_data), 64'(8'h20));

    // Pointer wrap: 12 write/read pairs through a 5-deep store.
    step(1'b1, 1'b1, 1'b1, 8'h00, "wrap_clr");
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h40 + 8'(k), "wrap_wr");
      step(1'b0, 1'b1, 1'b0, 8'h00, "wrap_rd");
      chk($sformatf("wrap%0d:dout", k), 64'(a_data), 64'(8'h40 + 8'(k)));
    end

    // Read on empty with a concurrent write.
    step(1'b1, 1'b1, 1'b1, 8'h00, "uf_clr");
    step(1'b0, 1'b0, 1'b0, 8'hA5, "uf_wr_rd");
    chk("uf:unf",    64'(a_unf),  64'(1));
    chk("uf:cnt",    64'(a_cnt),  64'(1));
    chk("uf:b_head", 64'(b_data), 64'(8'hA5));
    step(1'b0, 1'b1, 1'b0, 8'h00, "uf_rd");
    chk("uf:dout",   64'(a_data), 64'(8'hA5));

    // FWFT: the word appears without a read strobe.
    step(1'b1, 1'b1, 1'b1, 8'h00, "fwft_clr");
    chk("fwft:empty_data", 64'(b_data), 64'(0));
    step(1'b0, 1'b0, 1'b1, 8'h3C, "fwft_wr");
    chk("fwft:data", 64'(b_data), 64'(8'h3C));

    // Thresholds, then clear with strobes active.
    step(1'b1, 1'b1, 1'b1, 8'h00, "th_clr");
    step(1'b0, 1'b1, 1'b0, 8'h00, "th_unf");
    chk("th:unf_set", 64'(a_unf), 64'(1));
    step(1'b0, 1'b0, 1'b1, 8'h11, "th_w1");
    chk("th:afull1", 64'(a_afull), 64'(0));
    step(1'b0, 1'b0, 1'b1, 8'h12, "th_w2");
    chk("th:afull2", 64'(a_afull), 64'(0));
    step(1'b0, 1'b0, 1'b1, 8'h13, "th_w3");
    chk("th:afull3", 64'(a_afull), 64'(1));
    step(1'b1, 1'b0, 1'b0, 8'h14, "th_clr2");
    chk("clr:cnt",   64'(a_cnt),   64'(0));
    chk("clr:empty", 64'(a_empty), 64'(1));
    chk("clr:afull", 64'(a_afull), 64'(0));
    chk("clr:unf",   64'(a_unf),   64'(0));
    chk("clr:data",  64'(a_data),  64'(0));

    // Asynchronous reset mid-operation drops stored words.
    step(1'b0, 1'b0, 1'b1, 8'h55, "mr_w1");
    step(1'b0, 1'b0, 1'b1, 8'h56, "mr_w2");
    step(1'b0, 1'b1, 1'b0, 8'h00, "mr_rd");
    @(negedge clk);
    n_we = 1'b1;
    n_re = 1'b1;
    rst  = 1'b0;
    #2;
    model_reset();
    chk("midrst:cnt",   64'(a_cnt),   64'(0));
    chk("midrst:empty", 64'(b_empty), 64'(1));
    chk("midrst:data",  64'(a_data),  64'(0));
    #1;
    rst = 1'b1;

    // Randomised traffic against the queue model, alternating fill- and drain-biased phases.
    for (int i = 0; i < 600; i++) begin
      int pw, pr;
      logic c;
      pw = ((i / 50) % 2 == 0) ? 75 : 30;
      pr = ((i / 50) % 2 == 0) ? 30 : 75;
      c  = ($urandom_range(0, 60) == 0);
      step(c, !($urandom_range(0, 99) < pw), !($urandom_range(0, 99) < pr),
           8'($urandom), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 128, storage capacity in words (2..1024, any integer).
REQ-003 SHALL provide parameter AFULL_TH, default DEPTH-4, count at or above which p_afull_o asserts.
REQ-004 SHALL provide parameter AEMPTY_TH, default 4, count at or below which p_aempty_o asserts.
REQ-005 SHALL provide parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL provide port clk  input  1  system clock.
REQ-007 SHALL provide port rst  input  1  reset; asynchronous, active-low.
REQ-008 SHALL provide port clr_i  input  1  synchronous flush, active-high.
REQ-009 SHALL provide port data_i  input  WIDTH  write data.
REQ-010 SHALL provide port n_we_i  input  1  write strobe, active-low.
REQ-011 SHALL provide port n_re_i  input  1  read strobe, active-low.
REQ-012 SHALL provide port data_o  output  WIDTH  read data.
REQ-013 SHALL provide ports p_empty_o, p_full_o, p_aempty_o, p_afull_o  output  1 each  status flags, active-high.
REQ-014 SHALL provide port count_o  output  CW=clog2(DEPTH+1)  words currently stored.
REQ-015 SHALL provide ports overflow_o, underflow_o  output  1 each  sticky error flags.

Function
REQ-016 SHALL hold exactly DEPTH words; full means count_o == DEPTH (no sacrificed slot).
REQ-017 SHALL accept a write on a clk edge when n_we_i == 0 and (not full, or a read is accepted on the same edge).
REQ-018 SHALL accept a read on a clk edge when n_re_i == 0 and not empty; a read attempted while empty is never accepted, even if a write is accepted on the same edge.
REQ-019 SHALL wrap the read and write pointers from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-020 SHALL update count_o on the edge: +1 for a write only, -1 for a read only, unchanged for both or neither.
REQ-021 SHALL derive all four status flags combinationally from the registered count: p_empty_o (count==0), p_full_o (count==DEPTH), p_aempty_o (count<=AEMPTY_TH), p_afull_o (count>=AFULL_TH).
REQ-022 SHALL, when FWFT=0, load data_o on the edge of an accepted read and hold it otherwise (1-cycle read latency).
REQ-023 SHALL, when FWFT=1, drive data_o with the head word whenever not empty (0-cycle latency); an accepted read advances to the next word; data_o is 0 while empty.
REQ-024 SHALL set overflow_o when a write is attempted while full with no read accepted on the same edge; the word is discarded.
REQ-025 SHALL set underflow_o when a read is attempted while empty.
REQ-026 SHALL clear overflow_o and underflow_o only by reset or clr_i.
REQ-027 SHALL, on clr_i==1, zero both pointers, count, and the sticky flags on that edge; clr_i SHALL take priority over simultaneous strobes, and data_o SHALL be cleared to 0.

Reset
REQ-028 SHALL, while rst==0, drive pointers=0, count_o=0, data_o=0, overflow_o=0, underflow_o=0, hence p_empty_o=1, p_aempty_o=1, p_full_o=0, p_afull_o=0.
REQ-029 SHALL discard all stored contents on reset mid-operation; the memory array is not reset.

Structure
REQ-030 SHALL take shared constants (default WIDTH/DEPTH, clog2 count-width function) from package fifo_pkg.
REQ-031 SHALL place storage in sub-module fifo_mem_dp (one write port, one asynchronous read port, no reset); pointers, count, flags and the output register stay in param_sync_fifo.

Verification
REQ-032 SHALL cover fill to full: DEPTH=5, write 0x01..0x06 -> count 5, p_full_o=1, overflow_o=1, 0x06 never read back.
REQ-033 SHALL cover wrap: DEPTH=5, FWFT=0, 12 interleaved write/read pairs -> read data equals write order, pointers wrap at 4->0.
REQ-034 SHALL cover simultaneous write+read while full -> both accepted, count stays DEPTH, no overflow.
REQ-035 SHALL cover read while empty with concurrent write 0xA5 -> underflow_o=1, count 1, 0xA5 is the next word read.
REQ-036 SHALL cover FWFT=1: write 0x3C to empty FIFO -> data_o=0x3C the next cycle without a read strobe.
REQ-037 SHALL cover thresholds and clear: AFULL_TH=3 -> p_afull_o rises on the 3rd write; clr_i -> count 0, flags cleared, p_empty_o=1 the next cycle.
